// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - RV32 memory-op encodings, LSU state type and lane helpers
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } lsu_state_t;

    // Exactly one of ld/st, and a funct3 that exists for that direction.
    function automatic logic f3_legal(input logic ld, input logic st, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (ld ^ st) begin
            case (f3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_BU, F3_HU:     ok = ld;
                default:          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Natural alignment by access size (f3[1:0] encodes size for every legal f3).
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = ~lo[0];
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = BE_B << lo;
            2'b01:   be = BE_H << {lo[1], 1'b0};
            default: be = BE_W;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane so the byte enables pick the right one.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_req_if.sv
// rtl/lsu_req_if.sv - word-addressed memory request/response bus
interface lsu_req_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - load lane select and sign/zero extension
module lsu_load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  f3,
    output logic [31:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/halfword out of the raw word, then extend per funct3.
    always_comb begin
        case (addr_lo)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   data = {24'd0, lane_b};
            F3_HU:   data = {16'd0, lane_h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_req.sv
// rtl/lsu_req.sv - RV32 load/store unit request sequencer
module lsu_req
    import rv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_ld,
    input  logic        ex_st,
    input  logic [2:0]  ex_f3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        stall,
    lsu_req_if.master   mem,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        fault
);
    lsu_state_t  state;
    lsu_state_t  state_nxt;
    logic        in_req;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [2:0]  op_f3;
    logic [4:0]  op_rd;
    logic        op_st;
    logic        op_ok;
    logic        accept;
    logic        reject;
    logic [31:0] align_data;

    // ex_* only matter in IDLE; everywhere else the op in flight owns the unit.
    assign op_ok  = f3_legal(ex_ld, ex_st, ex_f3) & addr_aligned(ex_f3, ex_addr[1:0]);
    assign accept = (state == ST_IDLE) & ex_valid & op_ok;
    assign reject = (state == ST_IDLE) & ex_valid & ~op_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, stall and request strobe.
    always_comb begin
        state_nxt = state;
        stall     = 1'b1;
        in_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = 1'b0;
                if (accept) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                in_req = 1'b1;
                if (mem.mem_gnt) state_nxt = op_st ? ST_IDLE : ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (mem.mem_rvalid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs are driven only while requesting so the bus idles at zero.
    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req & op_st;
    assign mem.mem_addr  = in_req ? {op_addr[31:2], 2'b00} : 32'd0;
    assign mem.mem_be    = in_req ? byte_enable(op_f3, op_addr[1:0]) : 4'd0;
    assign mem.mem_wdata = in_req ? store_data(op_f3, op_wdata) : 32'd0;

    // Capture the accepted op so upstream may move on once stall drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_addr  <= 32'd0;
            op_wdata <= 32'd0;
            op_f3    <= 3'd0;
            op_rd    <= 5'd0;
            op_st    <= 1'b0;
        end else if (accept) begin
            op_addr  <= ex_addr;
            op_wdata <= ex_wdata;
            op_f3    <= ex_f3;
            op_rd    <= ex_rd;
            op_st    <= ex_st;
        end
    end

    lsu_load_align u_align (
        .rdata   (mem.mem_rdata),
        .addr_lo (op_addr[1:0]),
        .f3      (op_f3),
        .data    (align_data)
    );

    // Registered fault pulse and load writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault    <= 1'b0;
            ld_valid <= 1'b0;
            ld_data  <= 32'd0;
            ld_rd    <= 5'd0;
        end else begin
            fault    <= reject;
            ld_valid <= (state == ST_WAIT_R) & mem.mem_rvalid;
            if ((state == ST_WAIT_R) && mem.mem_rvalid) begin
                ld_data <= align_data;
                ld_rd   <= op_rd;
            end
        end
    end
endmodule

// File: tb/tb_lsu_req.sv
// tb/tb_lsu_req.sv - randomized self-checking bench for lsu_req
module tb_lsu_req;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ld, ex_st;
    logic [2:0]  ex_f3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall, ld_valid, fault;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] data; logic [4:0] rd; } ld_t;
    req_t req_q[$];
    ld_t  ld_q[$];
    int   fault_pend = 0;

    int          obs_stall;
    logic        obs_fault, obs_req_seen;
    logic [31:0] obs_addr, obs_wdata, obs_ld_data;
    logic [3:0]  obs_be;

    always #5 clk = ~clk;

    lsu_req_if mem();

    lsu_req dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ld(ex_ld), .ex_st(ex_st), .ex_f3(ex_f3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .stall(stall), .mem(mem),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd), .fault(fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned op_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit op_ok(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr);
        if (ld == st) return 0;
        if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        return (addr % op_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned off = addr % 4;
        case (op_size(f3))
            1:       return 4'(1 << off);
            2:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (op_size(f3))
            1:       return (w & 32'hFF) * 32'h0101_0101;
            2:       return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] lane = rdata >> (8 * (addr % 4));
        logic [31:0] v;
        case (op_size(f3))
            1: begin
                v = lane & 32'hFF;
                if (!f3[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            2: begin
                v = lane & 32'hFFFF;
                if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Continuous compare against the expectation queues, half a cycle after each edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (mem.mem_req) begin
                    check("req_expected", 32'(req_q.size() != 0), 1);
                    if (req_q.size() != 0) begin
                        check("mem_addr", mem.mem_addr, req_q[0].addr);
                        check("mem_be", 32'(mem.mem_be), 32'(req_q[0].be));
                        check("mem_we", 32'(mem.mem_we), 32'(req_q[0].we));
                        if (req_q[0].we) check("mem_wdata", mem.mem_wdata, req_q[0].wdata);
                        if (mem.mem_gnt) void'(req_q.pop_front());
                    end
                end
                if (ld_valid) begin
                    check("ld_expected", 32'(ld_q.size() != 0), 1);
                    if (ld_q.size() != 0) begin
                        check("ld_data", ld_data, ld_q[0].data);
                        check("ld_rd", 32'(ld_rd), 32'(ld_q[0].rd));
                        void'(ld_q.pop_front());
                    end
                end
                if (fault) begin
                    check("fault_expected", 32'(fault_pend != 0), 1);
                    if (fault_pend != 0) fault_pend--;
                end
            end
        end
    end

    task automatic garbage_ex();
        ex_valid = 1'($urandom);
        ex_ld    = 1'($urandom);
        ex_st    = 1'($urandom);
        ex_f3    = 3'($urandom);
        ex_addr  = $urandom;
        ex_wdata = $urandom;
        ex_rd    = 5'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 0);
        check({tag, "_mem_req"}, 32'(mem.mem_req), 0);
        check({tag, "_mem_we"}, 32'(mem.mem_we), 0);
        check({tag, "_mem_addr"}, mem.mem_addr, 0);
        check({tag, "_mem_be"}, 32'(mem.mem_be), 0);
        check({tag, "_mem_wdata"}, mem.mem_wdata, 0);
        check({tag, "_ld_valid"}, 32'(ld_valid), 0);
        check({tag, "_ld_data"}, ld_data, 0);
        check({tag, "_ld_rd"}, 32'(ld_rd), 0);
        check({tag, "_fault"}, 32'(fault), 0);
    endtask

    // Runs one op; starts and ends at a falling edge. g/r = grant/rvalid wait cycles.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int g, input int r, input bit abort);
        bit   ok;
        req_t e;
        ld_t  l;
        ok = op_ok(ld, st, f3, addr);
        if (ok) begin
            e.addr = addr & 32'hFFFF_FFFC; e.be = exp_be(f3, addr); e.we = st; e.wdata = exp_wdata(f3, wdata);
            req_q.push_back(e);
            if (ld && !abort) begin
                l.data = exp_load(rdata, addr, f3); l.rd = rd;
                ld_q.push_back(l);
            end
        end else begin
            fault_pend++;
        end
        ex_valid = 1'b1; ex_ld = ld; ex_st = st; ex_f3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        mem.mem_gnt = 1'($urandom); mem.mem_rvalid = 1'($urandom); mem.mem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        obs_stall = 0; obs_fault = fault; obs_req_seen = mem.mem_req;
        if (!ok) begin
            check("fault_pulse", 32'(fault), 1);
            check("fault_no_req", 32'(mem.mem_req), 0);
            check("fault_no_stall", 32'(stall), 0);
            ex_valid = 1'b0; mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
            return;
        end
        check("accept_no_fault", 32'(fault), 0);
        obs_addr = mem.mem_addr; obs_be = mem.mem_be; obs_wdata = mem.mem_wdata;
        for (int k = 0; k <= g; k++) begin
            obs_stall += int'(stall);
            garbage_ex();
            mem.mem_gnt = (k == g); mem.mem_rvalid = 1'($urandom); mem.mem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
        end
        if (st) begin
            ex_valid = 1'b0; mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
            check("st_stall_cycles", 32'(obs_stall), 32'(g + 1));
            check("st_done_stall", 32'(stall), 0);
            return;
        end
        if (abort) begin
            ex_valid = 1'b0; mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
            check("abort_in_wait", 32'(stall), 1);
            rst = 1'b1;
            @(posedge clk); @(negedge clk);
            check_all_zero("abort_rst");
            rst = 1'b0; mem.mem_rvalid = 1'b1; mem.mem_rdata = rdata;
            @(posedge clk); @(negedge clk);
            mem.mem_rvalid = 1'b0;
            check_all_zero("abort_late_rvalid");
            return;
        end
        for (int k = 0; k <= r; k++) begin
            obs_stall += int'(stall);
            garbage_ex();
            mem.mem_gnt = 1'($urandom); mem.mem_rvalid = (k == r);
            mem.mem_rdata = (k == r) ? rdata : $urandom;
            @(posedge clk); @(negedge clk);
        end
        ex_valid = 1'b0; mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
        check("ld_stall_cycles", 32'(obs_stall), 32'(g + r + 2));
        check("ld_done_stall", 32'(stall), 0);
        check("ld_valid_now", 32'(ld_valid), 1);
        obs_ld_data = ld_data;
    endtask

    initial begin
        logic        ld, st;
        int          kind;
        rst = 1'b1; ex_valid = 1'b0; ex_ld = 1'b0; ex_st = 1'b0; ex_f3 = 3'd0;
        ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); @(negedge clk);

        // SB 0x103, grant in the first request cycle
        do_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 5'd0, 32'd0, 0, 0, 1'b0);
        check("sb_addr", obs_addr, 32'h100);
        check("sb_be", 32'(obs_be), 32'b1000);
        check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        check("sb_stall", 32'(obs_stall), 1);

        // LH 0x202, two grant waits
        do_op(1'b1, 1'b0, 3'b001, 32'h202, 32'd0, 5'd7, 32'h8001_1234, 2, 1, 1'b0);
        check("lh_data", obs_ld_data, 32'hFFFF_8001);

        do_op(1'b1, 1'b0, 3'b100, 32'h001, 32'd0, 5'd3, 32'h0000_F000, 0, 0, 1'b0);
        check("lbu_data", obs_ld_data, 32'h0000_00F0);
        do_op(1'b1, 1'b0, 3'b010, 32'h000, 32'd0, 5'd4, 32'h0000_F000, 1, 2, 1'b0);
        check("lw_data", obs_ld_data, 32'h0000_F000);

        do_op(1'b0, 1'b1, 3'b010, 32'h006, 32'h1234_5678, 5'd0, 32'd0, 0, 0, 1'b0);
        check("sw_mis_fault", 32'(obs_fault), 1);
        check("sw_mis_noreq", 32'(obs_req_seen), 0);
        do_op(1'b1, 1'b0, 3'b101, 32'h005, 32'd0, 5'd1, 32'd0, 0, 0, 1'b0);
        check("lhu_mis_fault", 32'(obs_fault), 1);
        do_op(1'b0, 1'b1, 3'b100, 32'h010, 32'h55, 5'd0, 32'd0, 0, 0, 1'b0);
        check("sb_f3_100_fault", 32'(obs_fault), 1);
        @(posedge clk); @(negedge clk);
        check("fault_one_cycle", 32'(fault), 0);

        // Reset while waiting for read data
        do_op(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd9, 32'hDEAD_BEEF, 1, 0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            ld = (kind < 5) || (kind == 9);
            st = (kind >= 5);
            do_op(ld, st, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                mem.mem_gnt = 1'($urandom); mem.mem_rvalid = 1'($urandom);
                @(posedge clk); @(negedge clk);
            end
            mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check("req_q_drained", 32'(req_q.size()), 0);
        check("ld_q_drained", 32'(ld_q.size()), 0);
        check("faults_drained", 32'(fault_pend), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
